sync_link_tx: RTL and testbench

- Clocked-to-asynchronous bridge that sits directly upstream of the async register/pipeline stages and drives their input link.
- Accepts words on a synchronous valid/ready port and buffers them in a small FIFO.
- Emits each word as one two-phase (transition-signalled) dual-rail token on the link, then waits for the link acknowledge before issuing the next token.
- Handles clock-domain crossing of the incoming ack internally.

---
 rtl/sync_link_tx.sv | 63 ++++++
 tb/tb_sync_link_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sync_link_tx.sv
// sync_link_tx: clocked valid/ready FIFO feeding a two-phase dual-rail async link with synchronized ack.
module sync_link_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  input  logic             out_ack,
  output logic             busy,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [SYNC_STAGES-1:0] sync;
  logic ack_phase, ack_sync, ack_evt, full, empty, push, pop;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign in_ready = !rst && !full;
  assign push = in_valid && in_ready;
  assign ack_sync = sync[SYNC_STAGES-1];
  assign ack_evt = ack_sync != ack_phase;
  assign busy = (state == WAIT) || !empty;
  always_comb begin
    pop = (state == IDLE) && !empty;
    state_n = (state == IDLE) ? (empty ? IDLE : WAIT) : (ack_evt ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
  // Rails toggle straight from flops: one transition per bit per token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      sync <= '0;
      ack_phase <= 1'b0;
      err <= 1'b0;
      out_t <= '0;
      out_f <= '0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
      sync <= {sync[SYNC_STAGES-2:0], out_ack};
      ack_phase <= ack_evt ? ack_sync : ack_phase;
      err <= err | (ack_evt && state == IDLE);
      if (pop) begin
        out_t <= out_t ^ mem[rd_ptr[AW-1:0]];
        out_f <= out_f ^ ~mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

// File: tb/tb_sync_link_tx.sv
// tb_sync_link_tx: directed stimulus with a token scoreboard decoding the dual-rail link.
module tb_sync_link_tx;
  localparam int W = 8, D = 4, S = 2, ACK_DLY = 3;
  logic clk = 0, rst = 1, in_valid = 0, ack_auto = 0, ack_man = 0;
  logic [W-1:0] in_data = '0, out_t, out_f, pt = '0, pf = '0, dt, df, snap;
  logic in_ready, busy, err, out_ack;
  int n_checks = 0, n_fail = 0, cyc = 0, launches = 0, owed = 0, ack_cnt = -1;
  int last_launch = -1, mode = 0, base, n;
  logic [W-1:0] exp_q[$];
  assign out_ack = ack_auto ^ ack_man;
  always #5 clk = ~clk;

  sync_link_tx #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_t(out_t), .out_f(out_f), .out_ack(out_ack), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: decode rail transitions into tokens, compare against queue, model downstream ack.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      pt = '0; pf = '0; last_launch = -1; owed = 0; ack_cnt = -1; ack_auto = 0;
    end else begin
      if (out_t !== pt || out_f !== pf) begin
        dt = out_t ^ pt;
        df = out_f ^ pf;
        check("rail_complete", {24'b0, dt ^ df}, 32'hFF);
        check("rail_exclusive", {24'b0, dt & df}, 32'h0);
        if (last_launch >= 0) check("launch_gap", {31'b0, (cyc - last_launch) >= S + 2}, 32'h1);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_token: got %0h expected none", dt);
        end else check("token_data", {24'b0, dt}, {24'b0, exp_q.pop_front()});
        pt = out_t; pf = out_f; last_launch = cyc; launches++;
        if (mode != 0) owed++;
      end
      if (ack_cnt > 0) ack_cnt--;
      if (ack_cnt == 0) begin ack_auto = ~ack_auto; ack_cnt = -1; end
      if (mode == 2 && owed > 0 && ack_cnt < 0) begin ack_cnt = ACK_DLY; owed--; end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [W-1:0] d);
    int k = 0;
    in_data = d; in_valid = 1;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got ready 0 expected 1");
    end else exp_q.push_back(d);
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || exp_q.size() != 0 || owed != 0 || ack_cnt >= 0) && k < 500) begin step(); k++; end
    check("drain_done", {31'b0, k < 500}, 32'h1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", {31'b0, in_ready}, 0);
    check("rst_out_t", {24'b0, out_t}, 0);
    check("rst_out_f", {24'b0, out_f}, 0);
    rst = 0;
    step();
    check("idle_ready", {31'b0, in_ready}, 1);
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_err", {31'b0, err}, 0);
    // single word, manual ack
    mode = 0;
    push(8'hA5);
    check("pre_launch_t", {24'b0, out_t}, 0);
    step();
    check("single_t", {24'b0, out_t}, 32'hA5);
    check("single_f", {24'b0, out_f}, 32'h5A);
    check("single_busy", {31'b0, busy}, 1);
    ack_man = ~ack_man;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    check("busy_fall_edges", n, S + 1);
    // burst with echoing ack
    mode = 2; base = launches;
    push(8'h00); push(8'hFF); push(8'h3C); push(8'hC3);
    drain();
    check("burst_count", launches - base, 4);
    // full FIFO with ack held
    mode = 1; base = launches;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("full_ready", {31'b0, in_ready}, 0);
    check("full_one_launch", launches - base, 1);
    mode = 2;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("ready_after_pop", launches - base, 2);
    drain();
    check("full_count", launches - base, 5);
    // spurious ack
    mode = 0; base = launches; snap = out_t;
    check("pre_spur_err", {31'b0, err}, 0);
    ack_man = ~ack_man;
    repeat (5) step();
    check("spur_err", {31'b0, err}, 1);
    check("spur_rails", {24'b0, out_t}, {24'b0, snap});
    check("spur_no_launch", launches - base, 0);
    mode = 2;
    push(8'h77);
    drain();
    check("spur_recover", launches - base, 1);
    check("spur_err_sticky", {31'b0, err}, 1);
    // reset mid-operation
    mode = 1;
    push(8'h81); push(8'h42); push(8'h24);
    step();
    check("mid_busy", {31'b0, busy}, 1);
    @(negedge clk); #1;
    rst = 1; ack_man = 0; exp_q.delete();
    #1;
    check("async_rst_t", {24'b0, out_t}, 0);
    check("async_rst_f", {24'b0, out_f}, 0);
    check("async_rst_ready", {31'b0, in_ready}, 0);
    check("async_rst_busy", {31'b0, busy}, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    step();
    check("post_rst_empty", {31'b0, busy}, 0);
    check("post_rst_err", {31'b0, err}, 0);
    mode = 2; base = launches;
    push(8'h5A);
    drain();
    check("post_rst_count", launches - base, 1);
    check("post_rst_t", {24'b0, out_t}, 32'h5A);
    check("post_rst_f", {24'b0, out_f}, 32'hA5);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
